// File: rtl/led_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : led_arb_pkg
//  Purpose  : Shared constants for the LED bank arbiter. Holds the pattern
//             width per requester and the 2-bit state encoding of the
//             arbiter FSM.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package led_arb_pkg;

    localparam int LED_W = 5;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_OWN  = 2'd1;
    localparam state_t ST_GAP  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin picker. Finds the first set request
//             bit searching upward from last+1 (mod NREQ).
//  Ports    : req  - request vector, one bit per requester
//             last - index of the most recent owner
//             any  - high when at least one request is set
//             idx  - index of the winning requester (valid when any=1)
//  Revision : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic            any,
    output logic [IW-1:0]   idx
);

    // Walk the search order backwards so the candidate closest to last+1
    // is the one written last and therefore wins.
    always_comb begin
        idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            logic [IW-1:0] cand;
            cand = IW'((int'(last) + k) % NREQ);
            if (req[cand]) begin
                idx = cand;
            end
        end
        any = |req;
    end

endmodule
`default_nettype wire

// File: rtl/led_bank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : led_bank_arbiter
//  Purpose  : Shares the LED bank (LED1..LED5, green, red) between NREQ
//             requesters with round-robin arbitration, a time-slice limit
//             and a one-cycle break-before-make gap between owners. While
//             nobody owns the bank the green LED shows a heartbeat.
//  Ports    : clk        - system clock
//             rst_n      - asynchronous reset, active-low
//             req        - level requests, one bit per requester
//             pat        - LED patterns, LED_W bits per requester, bit0->LED1
//             gnt        - registered one-hot grant
//             led1..led5 - registered active-high LEDs
//             ledg_n     - green LED, active-low, heartbeat while idle
//             ledr_n     - red LED, active-low, lit while an owner drives
//  Revision : 1.0  initial release
// ============================================================================
module led_bank_arbiter
    import led_arb_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int SLICE_LOG2 = 22,
    parameter int HB_BIT     = 23
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LED_W-1:0] pat,
    output logic [NREQ-1:0]       gnt,
    output logic                  led1,
    output logic                  led2,
    output logic                  led3,
    output logic                  led4,
    output logic                  led5,
    output logic                  ledg_n,
    output logic                  ledr_n
);

    localparam int IW = $clog2(NREQ);
    localparam logic [IW-1:0]   LAST_RST = IW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    state_t                 state, next_state;
    logic [IW-1:0]          last_owner, next_owner;  // current owner while in OWN
    logic [SLICE_LOG2-1:0]  slice_cnt;
    logic [HB_BIT:0]        hb, hb_next;

    logic                   pick_any;
    logic [IW-1:0]          pick_idx;
    logic                   slice_exp;
    logic                   other_req;
    logic                   hold;

    logic [LED_W-1:0]       pat_arr [NREQ];
    logic [NREQ-1:0]        owner_oh;

    logic [NREQ-1:0]        gnt_d;
    logic [LED_W-1:0]       led_d, led_q;
    logic                   ledg_d, ledr_d;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_pat_split
            assign pat_arr[gi] = pat[gi*LED_W +: LED_W];
        end
    endgenerate

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req  (req),
        .last (last_owner),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    assign hb_next   = hb + 1'b1;
    assign slice_exp = &slice_cnt;
    assign owner_oh  = ONE_HOT0 << last_owner;
    assign other_req = |(req & ~owner_oh);

    // State register and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_owner <= LAST_RST;
            slice_cnt  <= '0;
            hb         <= '0;
        end else begin
            state      <= next_state;
            last_owner <= next_owner;
            hb         <= hb_next;
            // Held at zero outside OWN so every OWN entry starts a full
            // slice; wraps naturally on expiry when the owner keeps the bank.
            if (state == ST_OWN) begin
                slice_cnt <= slice_cnt + 1'b1;
            end else begin
                slice_cnt <= '0;
            end
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        next_owner = last_owner;
        case (state)
            ST_IDLE, ST_GAP: begin
                if (pick_any) begin
                    next_state = ST_OWN;
                    next_owner = pick_idx;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_OWN: begin
                // Release and expiry on the same edge collapse into one GAP.
                if (!req[last_owner] || (slice_exp && other_req)) begin
                    next_state = ST_GAP;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Output logic: values loaded into the output registers at the edge.
    // The grant follows the state being entered; LEDs and the red LED only
    // follow the owner's pattern once it has already held the bank for a
    // cycle, giving the one-cycle pattern delay.
    always_comb begin
        hold   = (state == ST_OWN) && (next_state == ST_OWN);
        gnt_d  = (next_state == ST_OWN) ? (ONE_HOT0 << next_owner) : '0;
        led_d  = hold ? pat_arr[last_owner] : '0;
        ledr_d = !hold;
        ledg_d = (next_state == ST_IDLE) ? hb_next[HB_BIT] : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt    <= '0;
            led_q  <= '0;
            ledg_n <= 1'b1;
            ledr_n <= 1'b1;
        end else begin
            gnt    <= gnt_d;
            led_q  <= led_d;
            ledg_n <= ledg_d;
            ledr_n <= ledr_d;
        end
    end

    assign led1 = led_q[0];
    assign led2 = led_q[1];
    assign led3 = led_q[2];
    assign led4 = led_q[3];
    assign led5 = led_q[4];

endmodule
`default_nettype wire
